// File: rtl/tone_classifier_pkg.sv
// Shared tone-direction definitions: band indices, FSM states,
// classification bundle and small helpers.
package tone_classifier_pkg;

  localparam int BAND_STRAIGHT = 0;
  localparam int BAND_LEFT     = 1;
  localparam int BAND_RIGHT    = 2;
  localparam int BAND_BACK     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    LOCK = 2'd2,
    HOLD = 2'd3
  } toneState_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] band;
  } toneCls_t;

  // |c - ctr| <= tol, written without a subtraction that can underflow.
  function automatic logic inBand(
    input int unsigned c,
    input int unsigned ctr,
    input int unsigned tol
  );
    return (c + tol >= ctr) && (c <= ctr + tol);
  endfunction

  function automatic logic [3:0] oneHot(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

endpackage

// File: rtl/tone_edge_counter.sv
// Synchronises micIn, detects rising edges and counts them per gate window.
// Ports: clk, rst (async low), enable, micIn -> count (incl. current edge), winClose.
module tone_edge_counter #(
  parameter int GATE_CYCLES = 500_000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             micIn,
  output logic [CNT_W-1:0] count,
  output logic             winClose
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  logic [2:0]       sync;
  logic             rise;
  logic [GW-1:0]    gate;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;

  assign rise     = sync[1] & ~sync[2];
  assign winClose = enable && (gate == GATE_LAST);

  // cntNext already includes an edge seen this cycle, so the
  // closing-cycle edge lands in the window being closed.
  assign cntNext = (rise && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  assign count   = cntNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], micIn};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate <= '0;
      cnt  <= '0;
    end else if (!enable) begin
      gate <= '0;
      cnt  <= '0;
    end else if (winClose) begin
      gate <= '0;
      cnt  <= '0;
    end else begin
      gate <= gate + GW'(1);
      cnt  <= cntNext;
    end
  end

endmodule

// File: rtl/tone_classifier.sv
// Audio tone front end: counts mic edges per window, classifies the count
// into four bands and drives a confirmed one-hot tone. Ports: clk, rst
// (async low), enable, micIn -> tone[3:0], toneValid, lastCount.
// Build option TONE_HYST_EN adds a HOLD state that rides out one missed window.
module tone_classifier
  import tone_classifier_pkg::*;
#(
  parameter int GATE_CYCLES = 500_000,
  parameter int CNT_W       = 16,
  parameter int CENTER0     = 10,
  parameter int CENTER1     = 15,
  parameter int CENTER2     = 20,
  parameter int CENTER3     = 25,
  parameter int TOL         = 2,
  parameter int CONFIRM     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             micIn,
  output logic [3:0]       tone,
  output logic             toneValid,
  output logic [CNT_W-1:0] lastCount
);

  localparam logic [7:0] CONF_K = 8'(CONFIRM);

  logic [CNT_W-1:0] count;
  logic             winClose;
  logic             winDone;
  toneCls_t         cls;
  toneCls_t         clsQ;

  toneState_t       state;
  toneState_t       stNext;
  logic [1:0]       band;
  logic [1:0]       bandNext;
  logic [7:0]       k;
  logic [7:0]       kNext;
  logic [7:0]       kInc;
  logic [3:0]       toneNext;

  tone_edge_counter #(
    .GATE_CYCLES(GATE_CYCLES),
    .CNT_W      (CNT_W)
  ) uCounter (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .micIn   (micIn),
    .count   (count),
    .winClose(winClose)
  );

  // Lowest band index wins if tolerances ever overlap.
  always_comb begin
    cls = '0;
    if (inBand(int'(count), CENTER0, TOL)) begin
      cls = '{hit: 1'b1, band: 2'(BAND_STRAIGHT)};
    end else if (inBand(int'(count), CENTER1, TOL)) begin
      cls = '{hit: 1'b1, band: 2'(BAND_LEFT)};
    end else if (inBand(int'(count), CENTER2, TOL)) begin
      cls = '{hit: 1'b1, band: 2'(BAND_RIGHT)};
    end else if (inBand(int'(count), CENTER3, TOL)) begin
      cls = '{hit: 1'b1, band: 2'(BAND_BACK)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastCount <= '0;
      clsQ      <= '0;
      winDone   <= 1'b0;
    end else begin
      winDone <= winClose;
      if (winClose) begin
        lastCount <= count;
        clsQ      <= cls;
      end
    end
  end

  assign kInc = k + 8'd1;

  always_comb begin
    stNext   = state;
    bandNext = band;
    kNext    = k;
    if (winDone) begin
      unique case (state)
        IDLE: begin
          if (clsQ.hit) begin
            bandNext = clsQ.band;
            kNext    = 8'd1;
            stNext   = (CONFIRM <= 1) ? LOCK : CAND;
          end
        end
        CAND: begin
          if (!clsQ.hit) begin
            stNext = IDLE;
            kNext  = '0;
          end else if (clsQ.band == band) begin
            kNext = kInc;
            if (kInc >= CONF_K) stNext = LOCK;
          end else begin
            bandNext = clsQ.band;
            kNext    = 8'd1;
          end
        end
        LOCK: begin
          if (!clsQ.hit) begin
`ifdef TONE_HYST_EN
            stNext = HOLD;
`else
            stNext = IDLE;
            kNext  = '0;
`endif
          end else if (clsQ.band != band) begin
            // A new band must earn its own confirmation run.
            stNext   = CAND;
            bandNext = clsQ.band;
            kNext    = 8'd1;
          end
        end
        HOLD: begin
`ifdef TONE_HYST_EN
          if (!clsQ.hit) begin
            stNext = IDLE;
            kNext  = '0;
          end else if (clsQ.band == band) begin
            stNext = LOCK;
          end else begin
            stNext   = CAND;
            bandNext = clsQ.band;
            kNext    = 8'd1;
          end
`else
          stNext = IDLE;
          kNext  = '0;
`endif
        end
        default: begin
          stNext = IDLE;
          kNext  = '0;
        end
      endcase
    end
    toneNext = ((stNext == LOCK) || (stNext == HOLD))
             ? oneHot(bandNext) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      band      <= '0;
      k         <= '0;
      tone      <= '0;
      toneValid <= 1'b0;
    end else if (!enable) begin
      state     <= IDLE;
      band      <= '0;
      k         <= '0;
      tone      <= '0;
      toneValid <= 1'b0;
    end else begin
      state     <= stNext;
      band      <= bandNext;
      k         <= kNext;
      tone      <= toneNext;
      toneValid <= |toneNext;
    end
  end

endmodule

// File: doc/tone_classifier.md
Name: tone_classifier

Overview:
- Upstream front end for the tone-direction stage. Replaces the push-button stand-ins with real audio-tone detection.
- Samples a 1-bit comparator-digitised microphone signal and counts rising edges over a fixed gate window.
- Classifies each window's count into one of four frequency bands. Drives a one-hot tone[3:0] that feeds pushBtn1..pushBtn4 of the direction stage; the pulse width there comes from how long the tone is held.

Parameters:
- GATE_CYCLES, 500_000, clk cycles per measurement window (10 ms at 50 MHz).
- CNT_W, 16, edge-counter width.
- CENTER0, 10, expected edges/window for band 0 (1.0 kHz, straight).
- CENTER1, 15, band 1 (1.5 kHz, left).
- CENTER2, 20, band 2 (2.0 kHz, right).
- CENTER3, 25, band 3 (2.5 kHz, back).
- TOL, 2, allowed ± deviation from a center, inclusive.
- CONFIRM, 3, consecutive matching windows required before asserting.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- enable  input  1  same signal as enableToneDetection; low clears the block
- micIn  input  1  asynchronous comparator output from the microphone
- tone  output  4  one-hot detected band; bit i drives pushBtn(i+1)
- toneValid  output  1  OR of tone bits, registered
- lastCount  output  CNT_W  edge count of the most recently closed window

Behaviour:
- Reset (rst=0, async): tone=0, toneValid=0, lastCount=0, all counters 0, FSM=IDLE, synchroniser flops 0.
- micIn passes through a 2-flop synchroniser and a third flop for edge detection. A rising edge is sync2=1 & sync3=0.
- Gate counter runs 0..GATE_CYCLES-1 and wraps.
- Window close is the cycle where gate==GATE_CYCLES-1. An edge detected on that cycle counts toward the closing window.
- The edge counter reloads to 0 on the cycle after close, or to 1 if an edge arrives on that cycle.
- The edge counter saturates at 2^CNT_W-1 and never wraps.
- On close, lastCount <= final count.
- Band match is |count-CENTERi| <= TOL. If more than one band matches, the lowest index wins. No match is a miss.
- Classification is registered one cycle after close. The FSM evaluates on that pulse (winDone).
- FSM states:
  - IDLE: on a match for band b → CAND with band=b, k=1. If CONFIRM==1, go straight to LOCK.
  - CAND: same band → k++; when k reaches CONFIRM → LOCK. Different band → restart CAND with the new band, k=1. Miss → IDLE.
  - LOCK: tone=onehot(band) and toneValid=1, both registered. Same band → stay. Miss or different band → release path (see Optional Feature). A different band always restarts CAND at k=1 and never re-locks immediately.
- Latency: tone asserts 2 clk after the close of the CONFIRM-th matching window. It deasserts 2 clk after the close of the releasing window.
- enable=0: synchronously clear counters, FSM→IDLE, tone=0, toneValid=0. lastCount keeps its value. On enable rising, the gate restarts at 0, so the first window is a full window.
- Reset mid-window: the partial count is discarded and there is no output glitch; outputs are 0 immediately.
- tone is never multi-hot. toneValid is exactly the OR of the tone bits.

Optional Feature:
- Macro: TONE_HYST_EN.
- Defined: LOCK + miss → HOLD state with outputs still asserted.
  - HOLD + same band → LOCK.
  - HOLD + second consecutive miss → IDLE, outputs cleared.
  - HOLD + different band → CAND with the new band, outputs cleared.
  - This tolerates single-window dropouts.
- Not defined: LOCK + miss → IDLE and outputs clear on the first missed window. The HOLD state is not built.

Decomposition:
- Shared package/header (alongside the direction-stage parameters): band index constants BAND_STRAIGHT=0, BAND_LEFT=1, BAND_RIGHT=2, BAND_BACK=3, and the FSM state encodings IDLE, CAND, LOCK, HOLD.
- One sub-module: tone_edge_counter. It holds the synchroniser, edge detect, gate counter and saturating edge counter. It outputs count and winClose.
- Classification and FSM stay in tone_classifier.

Test Plan (GATE_CYCLES=1000, other parameters default):
- Square wave, period 100 clk (10 edges/window), 4 windows → lastCount=10; tone=4'b0001 two clk after the 3rd window close.
- Period ~91 clk (11 edges) then period 50 clk (20 edges) → band0 count reaches 2, then CAND restarts on band2; tone=4'b0100 only after 3 band2 windows; never multi-hot.
- Lock band1 (15 edges), then one silent window:
  - without TONE_HYST_EN, tone→0 two clk after the silent close;
  - with TONE_HYST_EN, tone holds, and returns to LOCK on the next 15-edge window.
- Counts 7 and 28 (outside ±2) → tone stays 0 and FSM stays IDLE; count 12 → band0 match (boundary inclusive).
- Edge injected exactly on the gate==999 cycle → counted in the closing window, and the next window starts at 0.
- Locked band3, then rst pulled low mid-window → tone=0 and toneValid=0 asynchronously. Repeat with enable=0 instead → cleared on the next clk, lastCount retained.
